// File: rtl/ann_pkg.sv
// Shared types and constants for the ANN systolic-array datapath.
// Holds data-format defaults, Q5.10 constants and the accumulator state type.
package ann_pkg;

   localparam int WIDTH_DEF    = 16;
   localparam int FRAC_BIT_DEF = 10;

   localparam logic [15:0] Q_ONE = 16'h0400;
   localparam logic [15:0] Q_MAX = 16'h7FFF;
   localparam logic [15:0] Q_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } acc_state_t;

endpackage

// File: rtl/sat_relu.sv
// Combinational ACC_W -> WIDTH signed saturation with optional ReLU.
// Ports: acc (wide signed sum), relu_en, y (saturated/rectified result).
module sat_relu #(
   parameter int ACC_W = 19,
   parameter int WIDTH = 16
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic                    relu_en,
   output logic [WIDTH-1:0]        y
);

   logic [ACC_W-WIDTH:0] top;
   logic                 ovf;
   logic [WIDTH-1:0]     sat;

   // The value fits in WIDTH bits only when every bit from the
   // WIDTH-1 position upward is a copy of the sign bit.
   always_comb begin
      top = acc[ACC_W-1:WIDTH-1];
      ovf = ~((&top) | ~(|top));
      sat = acc[WIDTH-1:0];
      if (ovf) begin
         sat = acc[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
      end
      y = sat;
      if (relu_en && sat[WIDTH-1]) begin
         y = '0;
      end
   end

endmodule

// File: rtl/psum_accum_relu.sv
// Column output stage: bias + NUM_TILES partial sums, saturate, ReLU.
// Ports: in_valid/in_ready/in_psum, bias_load/bias_in, relu_en,
//        out_valid/out_ready/out_data, busy.
module psum_accum_relu
   import ann_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int FRAC_BIT  = FRAC_BIT_DEF,
   parameter int NUM_TILES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_psum,
   input  logic             bias_load,
   input  logic [WIDTH-1:0] bias_in,
   input  logic             relu_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   // Bias plus NUM_TILES terms always fits, so the sum never wraps.
   localparam int ACC_W = WIDTH + $clog2(NUM_TILES) + 1;
   localparam int CNT_W = $clog2(NUM_TILES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TILES);

   if (FRAC_BIT >= WIDTH || NUM_TILES < 1 || NUM_TILES > 256) begin : g_bad_cfg
      $error("psum_accum_relu: illegal parameter set");
   end

   acc_state_t              state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] acc_nxt;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic [WIDTH-1:0]        bias;
   logic [WIDTH-1:0]        bias_eff;
   logic [WIDTH-1:0]        res;
   logic                    accept;
   logic                    last;

   assign in_ready = (state != EMIT);
   assign busy     = (state != IDLE);
   assign accept   = in_valid & in_ready;

   // The first beat starts from the bias; a bias loaded on that same
   // cycle takes effect immediately.
   always_comb begin
      bias_eff = bias_load ? bias_in : bias;
      if (state == IDLE) begin
         base    = {{(ACC_W-WIDTH){bias_eff[WIDTH-1]}}, bias_eff};
         cnt_nxt = CNT_W'(1);
      end else begin
         base    = acc;
         cnt_nxt = cnt + 1'b1;
      end
      acc_nxt = base + {{(ACC_W-WIDTH){in_psum[WIDTH-1]}}, in_psum};
      last    = (cnt_nxt == LAST);
   end

   sat_relu #(
      .ACC_W (ACC_W),
      .WIDTH (WIDTH)
   ) u_sat (
      .acc     (acc_nxt),
      .relu_en (relu_en),
      .y       (res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         bias      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bias_load) begin
                  bias <= bias_in;
               end
               if (accept) begin
                  acc <= acc_nxt;
                  cnt <= cnt_nxt;
                  if (last) begin
                     out_data  <= res;
                     out_valid <= 1'b1;
                     state     <= EMIT;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= acc_nxt;
                  cnt <= cnt_nxt;
                  if (last) begin
                     out_data  <= res;
                     out_valid <= 1'b1;
                     state     <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  cnt       <= '0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum_relu.sv
// Self-checking bench for psum_accum_relu: directed cases plus random
// traffic compared against an integer-arithmetic reference model.
module tb_psum_accum_relu;

   localparam int NT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_psum;
   logic        bias_load;
   logic [15:0] bias_in;
   logic        relu_en;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // reference model state: group contents as integers
   int  m_bias;
   int  m_sum;
   int  m_n;
   bit  m_pend;
   int  m_res;

   always #5 clk = ~clk;

   psum_accum_relu #(
      .WIDTH     (16),
      .FRAC_BIT  (10),
      .NUM_TILES (NT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_psum   (in_psum),
      .bias_load (bias_load),
      .bias_in   (bias_in),
      .relu_en   (relu_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_out(input int s, input bit relu);
      int r;
      r = s;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return 16'(r);
   endfunction

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   task automatic model_reset();
      m_bias = 0;
      m_sum  = 0;
      m_n    = 0;
      m_pend = 1'b0;
      m_res  = 0;
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".rdy"}, 32'(in_ready), 32'(!m_pend));
      check({tag, ".busy"}, 32'(busy), 32'(m_pend || m_n != 0));
      check({tag, ".ov"}, 32'(out_valid), 32'(m_pend));
      if (m_pend) check({tag, ".od"}, 32'(out_data), 32'(m_res[15:0]));
   endtask

   // advance one clock: update model with current inputs, then check
   task automatic cyc(input string tag);
      if (!rst_n) begin
         model_reset();
      end else if (!m_pend) begin
         if (m_n == 0 && bias_load) m_bias = sx(bias_in);
         if (in_valid) begin
            if (m_n == 0) m_sum = m_bias;
            m_sum += sx(in_psum);
            m_n++;
            if (m_n == NT) begin
               m_res  = int'(ref_out(m_sum, relu_en));
               m_pend = 1'b1;
               m_n    = 0;
            end
         end
      end else if (out_ready) begin
         m_pend = 1'b0;
      end
      @(posedge clk);
      #1;
      check_outs(tag);
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_psum   = '0;
      bias_load = 1'b0;
      bias_in   = '0;
      relu_en   = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic load_bias(input logic [15:0] b);
      bias_load = 1'b1;
      bias_in   = b;
      cyc("bias");
      bias_load = 1'b0;
   endtask

   task automatic group(input logic [15:0] p0, p1, p2, p3, input bit relu);
      logic [15:0] ps [4];
      ps = '{p0, p1, p2, p3};
      relu_en = relu;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_psum  = ps[i];
         cyc("grp");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      cyc("drain");
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] held;
      int          acc_cnt;
      bit          vpat [7];

      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #12;
      check("rst.ov", 32'(out_valid), 32'd0);
      check("rst.od", 32'(out_data), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.rdy", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("idle");

      // basic group
      load_bias(16'h0400);
      group(16'h0400, 16'h0200, 16'hFE00, 16'h0100, 1'b0);
      check("t1.val", 32'(out_data), 32'h0900);
      drain();

      // saturation and ReLU
      load_bias(16'h0000);
      group(16'h7000, 16'h7000, 16'h7000, 16'h7000, 1'b0);
      check("sat.pos", 32'(out_data), 32'h7FFF);
      drain();
      group(16'h9000, 16'h9000, 16'h9000, 16'h9000, 1'b0);
      check("sat.neg", 32'(out_data), 32'h8000);
      drain();
      group(16'h9000, 16'h9000, 16'h9000, 16'h9000, 1'b1);
      check("sat.relu", 32'(out_data), 32'h0000);
      drain();

      // negative bias
      load_bias(16'hF800);
      group(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
      check("nb.relu", 32'(out_data), 32'h0000);
      drain();
      group(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
      check("nb.raw", 32'(out_data), 32'hFC00);

      // back-pressure for 5 cycles, then release with next beat waiting
      held = out_data;
      for (int i = 0; i < 5; i++) begin
         cyc("bp");
         check("bp.rdy", 32'(in_ready), 32'd0);
         check("bp.hold", 32'(out_data), 32'(held));
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_psum   = 16'h0100;
      cyc("rel");
      check("rel.rdy", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      cyc("rel.acc");
      check("rel.busy", 32'(busy), 32'd1);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         cyc("rel.grp");
      end
      in_valid = 1'b0;
      check("rel.res", 32'(out_data), 32'hFC00);
      drain();

      // gapped input
      load_bias(16'h0400);
      vpat = '{1, 0, 0, 1, 1, 0, 1};
      acc_cnt = 0;
      relu_en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = vpat[i];
         unique case (acc_cnt)
            0: in_psum = 16'h0400;
            1: in_psum = 16'h0200;
            2: in_psum = 16'hFE00;
            default: in_psum = 16'h0100;
         endcase
         if (in_valid && in_ready) acc_cnt++;
         cyc("gap");
      end
      in_valid = 1'b0;
      check("gap.cnt", 32'(acc_cnt), 32'd4);
      check("gap.res", 32'(out_data), 32'h0900);
      drain();

      // reset mid-group
      load_bias(16'h0400);
      in_valid = 1'b1;
      in_psum  = 16'h1000;
      cyc("pre");
      cyc("pre");
      in_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mr.ov", 32'(out_valid), 32'd0);
      check("mr.busy", 32'(busy), 32'd0);
      check("mr.rdy", 32'(in_ready), 32'd1);
      cyc("mr");
      rst_n = 1'b1;
      group(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
      check("mr.res", 32'(out_data), 32'h0400);
      drain();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_psum   = 16'($urandom);
         bias_load = ($urandom_range(0, 5) == 0);
         bias_in   = 16'($urandom);
         relu_en   = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 120) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_outs("rnd.rst");
         end else begin
            rst_n = 1'b1;
         end
         cyc("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
